// File: rtl/store_buffer_if.sv
// Core-side and memory-side signals of the store buffer, bundled as one interface.
// master = core/memory environment, slave = store_buffer.
interface store_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  st_valid;
  logic [DATA_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  st_ready;

  logic                  ld_valid;
  logic [DATA_WIDTH-1:0] ld_addr;
  logic                  ld_ready;
  logic [DATA_WIDTH-1:0] ld_rdata;

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_rd;

  logic [CNT_W-1:0]      count;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rd,
    input  st_ready, ld_ready, ld_rdata, mem_we, mem_a, mem_wd, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rd,
    output st_ready, ld_ready, ld_rdata, mem_we, mem_a, mem_wd, count
  );
endinterface

// File: rtl/store_buffer.sv
// Circular-FIFO store buffer sharing a single data-memory port with loads.
// Define STORE_BUFFER_FWD_EN to enable store-to-load forwarding (drain pauses during loads).
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_BITS  = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  store_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [CNT_W-1:0]      count_q;

  logic push;
  logic pop;
  logic load_go;

  // A full buffer refuses the push even when it pops in the same cycle.
  assign bus.st_ready = (count_q < FULL);
  assign push         = bus.st_valid && bus.st_ready;
  assign load_go      = bus.ld_valid && bus.ld_ready;
  assign bus.count    = count_q;

`ifdef STORE_BUFFER_FWD_EN
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [PTR_W-1:0]      fwd_idx;

  assign bus.ld_ready = 1'b1;
  assign pop          = !bus.ld_valid && (count_q != '0);

  // Walk oldest to youngest so the last match wins; only entries held at cycle start are visible.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) &&
          (addr_q[fwd_idx][ADDR_BITS-1:0] == bus.ld_addr[ADDR_BITS-1:0])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign bus.ld_rdata = fwd_hit ? fwd_data : bus.mem_rd;
`else
  logic [ADDR_BITS-1:0] unused_ld_addr_lsbs;

  assign unused_ld_addr_lsbs = bus.ld_addr[ADDR_BITS-1:0];
  assign bus.ld_ready        = (count_q == '0);
  assign pop                 = !load_go && (count_q != '0);
  assign bus.ld_rdata        = bus.mem_rd;
`endif

  // Port arbitration: a completing load owns the port, otherwise the head drains.
  // Gating on rst_n keeps the port quiet the instant reset asserts.
  always_comb begin
    bus.mem_we = 1'b0;
    bus.mem_a  = '0;
    bus.mem_wd = '0;
    if (rst_n) begin
      if (load_go) begin
        bus.mem_a = bus.ld_addr;
      end else if (pop) begin
        bus.mem_we = 1'b1;
        bus.mem_a  = addr_q[head_q];
        bus.mem_wd = data_q[head_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload needs no reset: validity is carried entirely by head and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.st_addr;
      data_q[tail_q] <= bus.st_data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes are queued at stimulus
// time and checked by an independent monitor; load and count behaviour checked directly.
module tb_store_buffer;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AB    = 10;
`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  wr_t exp_q[$];
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  store_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  store_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.mem_rd = mem[bus.mem_a[7:0]];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_a[7:0]] <= bus.mem_wd;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Independent monitor: every memory write must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n && bus.mem_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                 bus.mem_a, bus.mem_wd);
      end else begin
        e = exp_q.pop_front();
        checkOutput("wr_addr", bus.mem_a, e.a);
        checkOutput("wr_data", bus.mem_wd, e.d);
      end
    end
  end

  task automatic applyStimulus(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                               input logic lv, input logic [31:0] la);
    bus.st_valid = sv;
    bus.st_addr  = sa;
    bus.st_data  = sd;
    bus.ld_valid = lv;
    bus.ld_addr  = la;
  endtask

  task automatic expectWrite(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitEmpty(input string name);
    for (int k = 0; k < 20; k++) begin
      if (bus.count == '0) break;
      tick();
    end
    checkOutput(name, 32'(bus.count), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Reset values
    #2;
    checkOutput("rst_st_ready", 32'(bus.st_ready), 32'd1);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_mem_a", bus.mem_a, 32'h0);
    checkOutput("rst_mem_wd", bus.mem_wd, 32'h0);
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // Single store drains on the following cycle
    applyStimulus(1'b1, 32'h10, 32'hAAAA_0001, 1'b0, 32'h0);
    expectWrite(32'h10, 32'hAAAA_0001);
    checkOutput("t1_st_ready", 32'(bus.st_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("t1_count_one", 32'(bus.count), 32'd1);
    checkOutput("t1_mem_we", 32'(bus.mem_we), 32'd1);
    checkOutput("t1_mem_a", bus.mem_a, 32'h10);
    checkOutput("t1_mem_wd", bus.mem_wd, 32'hAAAA_0001);
    tick();
    checkOutput("t1_count_zero", 32'(bus.count), 32'd0);
    checkOutput("t1_idle_we", 32'(bus.mem_we), 32'd0);
    checkOutput("t1_idle_a", bus.mem_a, 32'h0);
    checkOutput("t1_mem", mem[8'h10], 32'hAAAA_0001);

    // Five stores with a load held; with forwarding the buffer fills and refuses the fifth
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'hA0 + 32'(4 * i), 32'h5000_0000 + 32'(i), 1'b1, 32'h3F0);
      checkOutput("t2_st_ready", 32'(bus.st_ready), FWD ? 32'(i < 4) : 32'd1);
      checkOutput("t2_mem_we", 32'(bus.mem_we), 32'(!FWD && i > 0));
      if (!FWD || i < 4) expectWrite(32'hA0 + 32'(4 * i), 32'h5000_0000 + 32'(i));
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h3F0);
    checkOutput("t2_count", 32'(bus.count), FWD ? 32'd4 : 32'd1);
    checkOutput("t2_st_ready_end", 32'(bus.st_ready), FWD ? 32'd0 : 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    waitEmpty("t2_drain");

`ifdef STORE_BUFFER_FWD_EN
    // Youngest matching entry is forwarded; same-cycle store stays invisible
    applyStimulus(1'b1, 32'h20, 32'h1, 1'b1, 32'h3F0);
    expectWrite(32'h20, 32'h1);
    tick();
    applyStimulus(1'b1, 32'h20, 32'h2, 1'b1, 32'h3F0);
    expectWrite(32'h20, 32'h2);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
    checkOutput("t3_fwd_data", bus.ld_rdata, 32'h2);
    checkOutput("t3_ld_ready", 32'(bus.ld_ready), 32'd1);
    checkOutput("t3_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("t3_mem_a", bus.mem_a, 32'h20);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h420);
    checkOutput("t3_fwd_high_bits", bus.ld_rdata, 32'h2);
    applyStimulus(1'b1, 32'h30, 32'h77, 1'b1, 32'h30);
    expectWrite(32'h30, 32'h77);
    checkOutput("t3_same_cycle", bus.ld_rdata, 32'hC0DE_0030);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    waitEmpty("t3_drain");
    checkOutput("t3_mem20", mem[8'h20], 32'h2);
`else
    // Load waits for two pending stores, then reads the freshly written memory
    applyStimulus(1'b1, 32'h44, 32'h1111, 1'b0, 32'h0);
    expectWrite(32'h44, 32'h1111);
    tick();
    applyStimulus(1'b1, 32'h40, 32'h5555, 1'b1, 32'h40);
    expectWrite(32'h40, 32'h5555);
    checkOutput("t4_ld_ready_1", 32'(bus.ld_ready), 32'd0);
    checkOutput("t4_drain_we", 32'(bus.mem_we), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
    checkOutput("t4_ld_ready_2", 32'(bus.ld_ready), 32'd0);
    checkOutput("t4_count", 32'(bus.count), 32'd1);
    tick();
    checkOutput("t4_ld_ready_3", 32'(bus.ld_ready), 32'd1);
    checkOutput("t4_ld_rdata", bus.ld_rdata, 32'h5555);
    checkOutput("t4_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("t4_mem_a", bus.mem_a, 32'h40);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
`endif

    // Reset in the middle of a drain discards the buffer without a write
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h60 + 32'(4 * i), 32'h6000_0000 + 32'(i), FWD, 32'h3F0);
      if (!FWD && i < 2) expectWrite(32'h60 + 32'(4 * i), 32'h6000_0000 + 32'(i));
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("t5_count_pre", 32'(bus.count), FWD ? 32'd3 : 32'd1);
    checkOutput("t5_we_pre", 32'(bus.mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_we_rst", 32'(bus.mem_we), 32'd0);
    checkOutput("t5_count_rst", 32'(bus.count), 32'd0);
    checkOutput("t5_st_ready_rst", 32'(bus.st_ready), 32'd1);
    checkOutput("t5_mem_a_rst", bus.mem_a, 32'h0);
    tick();
    checkOutput("t5_mem68", mem[8'h68], 32'hC0DE_0068);
    checkOutput("t5_mem60", mem[8'h60], FWD ? 32'hC0DE_0060 : 32'h6000_0000);
    checkOutput("t5_mem64", mem[8'h64], FWD ? 32'hC0DE_0064 : 32'h6000_0001);
    #3 rst_n = 1'b1;
    tick();

    // Simultaneous push and drain with pointer wrap
    applyStimulus(1'b1, 32'h80, 32'h8000_0000, 1'b0, 32'h0);
    expectWrite(32'h80, 32'h8000_0000);
    tick();
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 32'h80 + 32'(4 * i), 32'h8000_0000 + 32'(i), 1'b0, 32'h0);
      expectWrite(32'h80 + 32'(4 * i), 32'h8000_0000 + 32'(i));
      checkOutput("t6_count", 32'(bus.count), 32'd1);
      checkOutput("t6_st_ready", 32'(bus.st_ready), 32'd1);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    waitEmpty("t6_drain");
    checkOutput("t6_mem_first", mem[8'h80], 32'h8000_0000);
    checkOutput("t6_mem_last", mem[8'hA8], 32'h8000_000A);

    tick();
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
